// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// bit-counter width helper.
package serial_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Counter must hold 0..WIDTH-1 and is never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: the only arithmetic element of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full_adder plus a carry flip-flop adds two
// WIDTH-bit unsigned operands LSB-first over WIDTH cycles. start launches an
// operation from IDLE or DONE; done pulses for one cycle with the result.
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic             load;
  logic             last;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Operands are only taken when no addition is in flight.
  assign load = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last = (cnt == LAST_BIT);

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at bit 0.
  // Written as shift/or so that WIDTH = 1 needs no special case.
  assign psum_nxt = (psum >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Next-state decode; unreachable encodings fall back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Shift registers, carry, counter and result registers; sum/cout only
  // change on the completing edge so partial results never reach the ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      psum  <= '0;
      cnt   <= '0;
      carry <= cin;
    end else if (state == ST_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      psum  <= psum_nxt;
      carry <= fa_cout;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= psum_nxt;
        cout <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for timing/protocol
// cases and a 4-bit instance for an exhaustive arithmetic sweep.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int vectors;
  int miscompares;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation with latency, busy-length and result checks.
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic cv, input logic [7:0] es, input logic ec);
    int cyc;
    int bcnt;
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    bcnt = 0;
    while (!done8 && cyc < 30) begin
      if (busy8) bcnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, 9);
    check({tag, " busy_cycles"}, bcnt, 8);
    check({tag, " busy_at_done"}, busy8, 0);
    check({tag, " sum"}, sum8, es);
    check({tag, " cout"}, cout8, ec);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done8, 0);
  endtask

  initial begin
    logic [7:0] es [3];
    logic       ec [3];
    logic [7:0] prev;
    logic [4:0] exp5;
    int cyc;
    int pulses;
    int unstable;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset sum", sum8, 0);
    check("reset cout", cout8, 0);
    rst = 1'b0;

    // Basic operand patterns
    run8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run8("ff_plus_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("a5_5a_cin", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    run8("3c_42", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);

    // Start re-pulsed during RUN must be ignored
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8) pulses++;
      @(negedge clk);
    end
    check("midrun done_pulses", pulses, 1);
    check("midrun sum", sum8, 8'h46);
    check("midrun cout", cout8, 0);

    // Start held high for three back-to-back operations
    es[0] = 8'h33; ec[0] = 1'b0;
    es[1] = 8'h00; ec[1] = 1'b1;
    es[2] = 8'h81; ec[2] = 1'b0;
    prev = 8'h46;
    unstable = 0;
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    cyc = 1;
    for (int k = 0; k < 3; k++) begin
      while (!done8 && cyc < 30) begin
        if (sum8 !== prev) unstable++;
        @(negedge clk);
        cyc++;
      end
      check($sformatf("held%0d period", k), cyc, 9);
      check($sformatf("held%0d sum", k), sum8, es[k]);
      check($sformatf("held%0d cout", k), cout8, ec[k]);
      prev = es[k];
      if (k == 2) start8 = 1'b0;
      @(negedge clk);
      cyc = 1;
      if (k == 0) begin
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b1;
      end
    end
    check("held sum_stable", unstable, 0);
    check("held idle_after", busy8, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort sum", sum8, 0);
    check("abort cout", cout8, 0);
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8) pulses++;
      @(negedge clk);
    end
    check("abort no_done", pulses, 0);
    run8("after_reset", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);

    // Exhaustive 4-bit sweep
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          @(negedge clk);
          a4 = 4'(av); b4 = 4'(bv); cin4 = 1'(cv); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          cyc = 1;
          while (!done4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
          end
          exp5 = 5'(av + bv + cv);
          check($sformatf("sweep4 %0d+%0d+%0d", av, bv, cv), {cout4, sum4}, exp5);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder built around the existing 1-bit `full_adder` cell: one full adder plus a carry flip-flop adds two WIDTH-bit operands LSB-first over WIDTH clock cycles. It is the sequential consumer of the `full_adder` sum/carry outputs. It serves area-constrained datapaths that accept multi-cycle latency in exchange for a single adder cell. Operands are accepted with a start pulse, and completion is signalled with a one-cycle done pulse.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 1 or greater.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to add `a`, `b` and `cin`; sampled on a rising edge.
- `a`  in  WIDTH  operand A; captured on an accepted start.
- `b`  in  WIDTH  operand B; captured on an accepted start.
- `cin`  in  1  carry-in; captured on an accepted start.
- `busy`  out  1  high while bit-serial addition is in progress.
- `done`  out  1  one-cycle pulse; `sum` and `cout` are valid from this cycle on.
- `sum`  out  WIDTH  registered result, equal to (a + b + cin) mod 2^WIDTH.
- `cout`  out  1  registered carry-out, equal to bit WIDTH of a + b + cin.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- Start is accepted in IDLE or DONE:
  - load shift registers `a_sh` ← `a` and `b_sh` ← `b`;
  - set carry FF ← `cin`, bit counter ← 0, partial-sum register ← 0;
  - go to RUN.
- Start is ignored in RUN, with no effect on the operation in progress.
- Each RUN cycle:
  - the `full_adder` inputs are `a_sh[0]`, `b_sh[0]` and the carry FF;
  - `a_sh` and `b_sh` shift right by 1, with zero fill;
  - the sum bit enters the partial-sum MSB, and the partial sum shifts right by 1;
  - carry FF ← full-adder `cout`; counter increments.
- When the counter reaches WIDTH-1, in the same edge:
  - copy the completed partial sum into `sum`;
  - copy the full-adder `cout` into `cout`;
  - go to DONE.
- DONE lasts exactly one cycle, during which `done` is 1. The FSM then returns to IDLE, unless a start is accepted in DONE, in which case it goes straight to RUN.
- `sum` and `cout` hold their last result until the next completion. They do not change during RUN. Partial results are never visible on the outputs.
- `busy` = (state == RUN). `done` = (state == DONE). Both are decoded from registered state, so they are glitch-free.
- Arithmetic:
  - counter width is max(1, $clog2(WIDTH));
  - there is no overflow indication other than `cout`;
  - operands are unsigned. Two's-complement callers read `sum` directly.
- WIDTH = 1 is legal and produces one RUN cycle.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0;
  - shift registers, carry FF and counter = 0.
- A reset asserted mid-operation aborts the addition. No `done` is produced, and outputs return to their reset values.
- Start sampled at edge E0:
  - `busy` = 1 after E0;
  - bits 0..WIDTH-1 are processed at edges E1..EWIDTH;
  - after EWIDTH: `busy` = 0, `done` = 1, and `sum`/`cout` are valid.
  - Latency from the start edge to `done` is WIDTH+1 cycles, inclusive of the start cycle.
- Throughput: back-to-back operations cost WIDTH+1 cycles each, with start held or re-pulsed in DONE.
- Start and reset asserted together: reset wins.
- Operands are captured only at the accepting edge. Changes to `a`, `b` or `cin` afterwards have no effect.

## Structure
- Shared package `serial_pkg`:
  - state encoding localparams `ST_IDLE` = 2'b00, `ST_RUN` = 2'b01, `ST_DONE` = 2'b10;
  - all other encodings are unreachable and recover to IDLE.
- One sub-module: the existing `full_adder` (ports `a`, `b`, `cin`, `sum`, `cout`), instantiated exactly once. No inline adder logic.
- Everything else (FSM, counter, shift registers, output registers) is in `serial_adder`.

## Test plan
- WIDTH=8: a=8'h00, b=8'h00, cin=0 → `done` 9 cycles after the start edge; `sum`=8'h00, `cout`=0; `busy` high for exactly 8 cycles.
- WIDTH=8: a=8'hFF, b=8'h01, cin=0 → `sum`=8'h00, `cout`=1. Then a=8'hA5, b=8'h5A, cin=1 → `sum`=8'h00, `cout`=1. Then a=8'h3C, b=8'h42, cin=0 → `sum`=8'h7E, `cout`=0.
- Start pulsed again mid-RUN with different operands → ignored. Result matches the first operands; exactly one `done` pulse.
- Start held high continuously for 3 operations → `done` every 9 cycles. Results are correct, and each `sum` is held stable between its `done` pulses.
- `rst` asserted 4 cycles into RUN, asynchronously between edges → outputs are 0 immediately and no `done` follows. The next start after reset gives the correct result.
- Self-checking sweep with WIDTH=4, all 512 combinations of a, b and cin → {`cout`,`sum`} == a+b+cin every time, using pass/fail counters and a summary line.
